// File: rtl/distributor14.sv
// Registered 1-to-4 data distributor with manual select and round-robin mode.
// Ports: iClk/iRst clock and sync reset; iD/iValid data in; iS1:iS0 manual
// select; iAuto mode; oC0..oC3 channel registers; oV write strobes;
// oSel next target; oFrame pulse after the 4th round-robin write.
module distributor14 (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [3:0] iD,
  input  logic       iValid,
  input  logic       iS0,
  input  logic       iS1,
  input  logic       iAuto,
  output logic [3:0] oC0,
  output logic [3:0] oC1,
  output logic [3:0] oC2,
  output logic [3:0] oC3,
  output logic [3:0] oV,
  output logic [1:0] oSel,
  output logic       oFrame
);

  logic [1:0] ptr;
  logic [1:0] tgt;

  // Mode is taken from the same edge as the write it steers.
  assign tgt  = iAuto ? ptr : {iS1, iS0};
  assign oSel = tgt;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oC0    <= '0;
      oC1    <= '0;
      oC2    <= '0;
      oC3    <= '0;
      oV     <= '0;
      oFrame <= 1'b0;
      ptr    <= '0;
    end else begin
      oV     <= '0;
      oFrame <= 1'b0;
      // Manual mode parks the pointer so auto always starts at channel 0.
      if (!iAuto) ptr <= '0;
      if (iValid) begin
        oV <= 4'b0001 << tgt;
        unique case (tgt)
          2'd0: oC0 <= iD;
          2'd1: oC1 <= iD;
          2'd2: oC2 <= iD;
          2'd3: oC3 <= iD;
          default: ;
        endcase
        if (iAuto) begin
          ptr    <= ptr + 2'd1;
          oFrame <= (ptr == 2'd3);
        end
      end
    end
  end

endmodule

// File: doc/distributor14.md
DISTRIBUTOR14 -- requirements
Module: distributor14

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have port iClk, input, 1 bit: rising-edge clock; all state changes occur on this edge only.
REQ-003 SHALL have port iRst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port iD, input, 4 bits: data word to distribute.
REQ-005 SHALL have port iValid, input, 1 bit: iD is valid this cycle.
REQ-006 SHALL have port iS0, input, 1 bit: manual select LSB.
REQ-007 SHALL have port iS1, input, 1 bit: manual select MSB.
REQ-008 SHALL have port iAuto, input, 1 bit: 1 = round-robin mode; 0 = manual mode.
REQ-009 SHALL have ports oC0, oC1, oC2 and oC3, outputs, 4 bits each: registered channel data holding registers.
REQ-010 SHALL have port oV, output, 4 bits: per-channel write strobe; bit n pulses for a written channel n.
REQ-011 SHALL have port oSel, output, 2 bits: channel index targeted by the next write.
REQ-012 SHALL have port oFrame, output, 1 bit: one-cycle pulse after the 4th write of a round-robin frame.

Function
REQ-013 SHALL be a registered 1-to-4 demultiplexer; write latency is 1 cycle (iD sampled at edge N appears on oCn after edge N).
REQ-014 Manual mode (iAuto=0): target channel SHALL be {iS1,iS0}, i.e. 00->oC0, 01->oC1, 10->oC2, 11->oC3.
REQ-015 Auto mode (iAuto=1): target channel SHALL be the internal 2-bit pointer ptr.
REQ-016 On an edge with iValid=1, oC[target] SHALL load iD, and all other oCn SHALL hold.
REQ-017 On an edge with iValid=0, all oCn SHALL hold their values.
REQ-018 oV SHALL be registered: after an edge with iValid=1, oV SHALL be one-hot at the target bit for exactly one cycle.
REQ-019 oV SHALL be 4'b0000 after any edge with iValid=0.
REQ-020 ptr SHALL increment by 1 mod 4 on each auto-mode write, wrapping 3->0.
REQ-021 ptr SHALL hold in auto mode when iValid=0.
REQ-022 While iAuto=0, ptr SHALL be forced to 0 at every edge, so entering auto mode always starts at channel 0.
REQ-023 iAuto SHALL be sampled on the same edge as iValid, so the mode in force at that edge selects the target.
REQ-024 oFrame SHALL be 1 for exactly the cycle after an auto-mode write with ptr=3; otherwise it SHALL be 0.
REQ-025 Manual-mode writes SHALL never assert oFrame.
REQ-026 oSel SHALL be combinational: {iS1,iS0} when iAuto=0, and ptr when iAuto=1.
REQ-027 iD, iS0 and iS1 SHALL be don't-care when iValid=0.
REQ-028 Back-to-back writes on every cycle SHALL be supported with no stall or bubble.
REQ-029 The block SHALL have no backpressure; every valid word SHALL be accepted.

Reset
REQ-030 After an edge with iRst=1: oC0..oC3 SHALL be 4'h0, oV 4'b0000, oFrame 0, and ptr 0.
REQ-031 iRst SHALL take priority over iValid on the same edge; the write is discarded and no oV pulse results.
REQ-032 Reset mid-frame SHALL restart the round robin at channel 0, and no oFrame is produced for the partial frame.

Verification
REQ-033 Reset then manual: iAuto=0, {iS1,iS0}=10, iD=4'h1, iValid=1 for 1 cycle -> next cycle oC2=4'h1, oV=4'b0100, oC0=oC1=oC3=4'h0; the following cycle oV=0.
REQ-034 Manual sweep, one write per 10 ns: select 00..11 with iD=1,0,0,0 -> oC0=1, oC1=oC2=oC3=0, and oV walks 0001,0010,0100,1000.
REQ-035 Auto frame: iAuto=1, iValid=1 for 4 consecutive cycles with iD=A,B,C,D -> oC0..oC3=A,B,C,D; oSel goes 0,1,2,3,0; oFrame=1 only in the cycle after D.
REQ-036 Auto with gaps: valid, idle, valid -> ptr advances only on valid cycles, and idle cycles give oV=0 with oCn unchanged.
REQ-037 Reset mid-frame: 2 auto writes, then iRst=1 together with iValid=1 -> all oCn=0, oV=0, no oFrame; the next auto write lands in oC0.
REQ-038 Mode switch: 2 auto writes, then 1 cycle iAuto=0 with iValid=0, then iAuto=1 with a write -> the write lands in oC0.
